// File: rtl/pipo_share_arbiter_if.sv
// Handshake/data bundle between two requesters and pipo_share_arbiter.
// Carries q_par only when PIPO_ARB_PARITY_EN is defined.
interface pipo_share_arbiter_if #(
  parameter int unsigned W = 4
);
  logic         req0;
  logic [W-1:0] d0;
  logic         req1;
  logic [W-1:0] d1;
  logic         gnt0;
  logic         gnt1;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_src;
  logic         busy;
`ifdef PIPO_ARB_PARITY_EN
  logic         q_par;
`endif

  modport master (
    output req0, d0, req1, d1,
`ifdef PIPO_ARB_PARITY_EN
    input  q_par,
`endif
    input  gnt0, gnt1, q, q_valid, q_src, busy
  );

  modport slave (
    input  req0, d0, req1, d1,
`ifdef PIPO_ARB_PARITY_EN
    output q_par,
`endif
    output gnt0, gnt1, q, q_valid, q_src, busy
  );
endinterface

// File: rtl/pipo_share_arbiter.sv
// Round-robin arbiter owning one shared W-bit holding register (IDLE/HOLD FSM).
// Optional parity output q_par enabled by defining PIPO_ARB_PARITY_EN.
module pipo_share_arbiter #(
  parameter int unsigned W           = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  pipo_share_arbiter_if.slave bus
);
  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic          q_valid_q, q_valid_d;
  logic          q_src_q, q_src_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          busy_q, busy_d;
  logic          pref_q, pref_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          win;
  logic [W-1:0]  win_data;
`ifdef PIPO_ARB_PARITY_EN
  logic          q_par_q, q_par_d;
`endif

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    q_src_d   = q_src_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    busy_d    = busy_q;
    pref_d    = pref_q;
    cnt_d     = cnt_q;
    // Contested requests go to the preferred side; a lone request always wins.
    win       = (bus.req0 && bus.req1) ? pref_q : bus.req1;
    win_data  = win ? bus.d1 : bus.d0;
`ifdef PIPO_ARB_PARITY_EN
    q_par_d   = q_par_q;
`endif
    case (state_q)
      IDLE: begin
        q_valid_d = 1'b0;
        busy_d    = 1'b0;
        if (bus.req0 || bus.req1) begin
          q_d       = win_data;
          q_src_d   = win;
          gnt0_d    = ~win;
          gnt1_d    = win;
          q_valid_d = 1'b1;
          busy_d    = 1'b1;
          pref_d    = ~win;
          cnt_d     = CW'(HOLD_CYCLES - 1);
          state_d   = HOLD;
`ifdef PIPO_ARB_PARITY_EN
          q_par_d   = ^win_data;
`endif
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          q_valid_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      q_src_q   <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      pref_q    <= 1'b0;
      cnt_q     <= '0;
`ifdef PIPO_ARB_PARITY_EN
      q_par_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      q_src_q   <= q_src_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      busy_q    <= busy_d;
      pref_q    <= pref_d;
      cnt_q     <= cnt_d;
`ifdef PIPO_ARB_PARITY_EN
      q_par_q   <= q_par_d;
`endif
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.q_src   = q_src_q;
  assign bus.busy    = busy_q;
`ifdef PIPO_ARB_PARITY_EN
  assign bus.q_par   = q_par_q;
`endif
endmodule

// File: tb/tb_pipo_share_arbiter.sv
// Directed self-checking bench for pipo_share_arbiter (W=4, HOLD_CYCLES=2).
// Parity scenario runs only when PIPO_ARB_PARITY_EN is defined.
module tb_pipo_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned errors = 0;
  int unsigned checks = 0;

  pipo_share_arbiter_if #(.W(4)) bus ();

  pipo_share_arbiter #(.W(4), .HOLD_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req0 = 1'b1; bus.req1 = 1'b1; bus.d0 = 4'b0110; bus.d1 = 4'b0011;
    tick(); tick();
    checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got=%b exp=0", bus.gnt0); end
    checks++; if (bus.gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt1 got=%b exp=0", bus.gnt1); end
    checks++; if (bus.q !== 4'b0000) begin errors++; $display("FAIL rst_q got=%b exp=0000", bus.q); end
    checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL rst_q_valid got=%b exp=0", bus.q_valid); end
    checks++; if (bus.q_src !== 1'b0) begin errors++; $display("FAIL rst_q_src got=%b exp=0", bus.q_src); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
`ifdef PIPO_ARB_PARITY_EN
    checks++; if (bus.q_par !== 1'b0) begin errors++; $display("FAIL rst_q_par got=%b exp=0", bus.q_par); end
`endif
    rst = 1'b0;
    tick();
    checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin errors++; $display("FAIL rst_first_gnt got=%b%b exp=01", bus.gnt1, bus.gnt0); end
    checks++; if (bus.q !== 4'b0110) begin errors++; $display("FAIL rst_first_q got=%b exp=0110", bus.q); end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_single();
    bus.req0 = 1'b1; bus.d0 = 4'b1001;
    tick();
    bus.req0 = 1'b0;
    checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin errors++; $display("FAIL single_gnt got=%b%b exp=01", bus.gnt1, bus.gnt0); end
    checks++; if (bus.q !== 4'b1001 || bus.q_src !== 1'b0) begin errors++; $display("FAIL single_q got=%b/%b exp=1001/0", bus.q, bus.q_src); end
    checks++; if (bus.q_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_v1 got=%b%b exp=11", bus.q_valid, bus.busy); end
    tick();
    checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL single_pulse got=%b exp=0", bus.gnt0); end
    checks++; if (bus.q_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_v2 got=%b%b exp=11", bus.q_valid, bus.busy); end
    tick();
    checks++; if (bus.q_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_v3 got=%b%b exp=00", bus.q_valid, bus.busy); end
    tick();
    checks++; if (bus.q !== 4'b1001 || bus.q_valid !== 1'b0) begin errors++; $display("FAIL single_retain got=%b/%b exp=1001/0", bus.q, bus.q_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_q;
    logic       exp_src;
    rst = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    rst = 1'b0; bus.req0 = 1'b1; bus.req1 = 1'b1; bus.d0 = 4'b1011; bus.d1 = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      exp_src = (i % 2 == 1);
      exp_q   = exp_src ? 4'b1111 : 4'b1011;
      tick();
      checks++; if (bus.gnt0 !== ~exp_src || bus.gnt1 !== exp_src) begin errors++; $display("FAIL b2b_gnt[%0d] got=%b%b exp=%b%b", i, bus.gnt1, bus.gnt0, exp_src, ~exp_src); end
      checks++; if (bus.q !== exp_q || bus.q_src !== exp_src) begin errors++; $display("FAIL b2b_q[%0d] got=%b/%b exp=%b/%b", i, bus.q, bus.q_src, exp_q, exp_src); end
      tick();
      checks++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.q_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold[%0d] got=%b%b%b exp=001", i, bus.gnt1, bus.gnt0, bus.q_valid); end
      tick();
      if (i == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      checks++; if (bus.q_valid !== 1'b0 || bus.busy !== 1'b0 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin errors++; $display("FAIL b2b_gap[%0d] got=v%b b%b g%b%b exp=v0 b0 g00", i, bus.q_valid, bus.busy, bus.gnt1, bus.gnt0); end
    end
  endtask

  task automatic test_req_during_hold();
    bus.req0 = 1'b1; bus.d0 = 4'b0101;
    tick();
    checks++; if (bus.gnt0 !== 1'b1 || bus.q !== 4'b0101) begin errors++; $display("FAIL hold_g0 got=%b/%b exp=1/0101", bus.gnt0, bus.q); end
    bus.req0 = 1'b0; bus.req1 = 1'b1; bus.d1 = 4'b0110;
    tick();
    checks++; if (bus.gnt1 !== 1'b0 || bus.q !== 4'b0101) begin errors++; $display("FAIL hold_ignore got=%b/%b exp=0/0101", bus.gnt1, bus.q); end
    tick();
    checks++; if (bus.gnt1 !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL hold_idle got=%b/%b exp=0/0", bus.gnt1, bus.busy); end
    tick();
    bus.req1 = 1'b0;
    checks++; if (bus.gnt1 !== 1'b1 || bus.q !== 4'b0110 || bus.q_src !== 1'b1) begin errors++; $display("FAIL hold_g1 got=%b/%b/%b exp=1/0110/1", bus.gnt1, bus.q, bus.q_src); end
  endtask

  task automatic test_reset_mid_hold();
    tick();
    checks++; if (bus.q_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL mid_pre got=%b%b exp=11", bus.q_valid, bus.busy); end
    rst = 1'b1; bus.req0 = 1'b1; bus.req1 = 1'b1; bus.d0 = 4'b0111; bus.d1 = 4'b1000;
    tick();
    checks++; if (bus.q !== 4'b0000 || bus.q_valid !== 1'b0 || bus.busy !== 1'b0 || bus.q_src !== 1'b0) begin errors++; $display("FAIL mid_rst got=q%b v%b b%b s%b exp=q0000 v0 b0 s0", bus.q, bus.q_valid, bus.busy, bus.q_src); end
    rst = 1'b0;
    tick();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.q !== 4'b0111) begin errors++; $display("FAIL mid_after got=g%b%b q%b exp=g01 q0111", bus.gnt1, bus.gnt0, bus.q); end
    tick(); tick(); tick();
  endtask

`ifdef PIPO_ARB_PARITY_EN
  task automatic test_parity();
    bus.req0 = 1'b1; bus.d0 = 4'b1011;
    tick();
    bus.req0 = 1'b0;
    checks++; if (bus.q_par !== 1'b1 || bus.q !== 4'b1011) begin errors++; $display("FAIL par_a got=%b/%b exp=1/1011", bus.q_par, bus.q); end
    tick(); tick();
    bus.req1 = 1'b1; bus.d1 = 4'b1001;
    tick();
    bus.req1 = 1'b0;
    checks++; if (bus.q_par !== 1'b0 || bus.q !== 4'b1001) begin errors++; $display("FAIL par_b got=%b/%b exp=0/1001", bus.q_par, bus.q); end
    tick(); tick();
  endtask
`endif

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.d0 = '0; bus.d1 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_req_during_hold();
    test_reset_mid_hold();
`ifdef PIPO_ARB_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
